// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline stages and the hazard controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(parameter int AW = 4);
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_gpr_write;
  logic          id_csr_access;
  logic          id_csr_write;
  logic          id_is_fence_i;
  logic [31:0]   id_pc;
  logic          idexe_in_ready;
  logic          idexe_valid;
  logic [AW-1:0] idexe_rd;
  logic          idexe_gpr_write;
  logic          idexe_csr_write;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          wb_gpr_write;
  logic          wb_csr_write;
  logic          pipe_empty;
  logic          exe_redirect;
  logic          icache_flush_done;
  logic          id_hold;
  logic          flush_if_id;
  logic          flush_id_exe;
  logic          icache_flush_req;
  logic          fencei_redirect;
  logic [31:0]   fencei_pc;
  logic          sb_error;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_gpr_write, id_csr_access, id_csr_write, id_is_fence_i, id_pc,
           idexe_in_ready, idexe_valid, idexe_rd, idexe_gpr_write,
           idexe_csr_write, wb_valid, wb_rd, wb_gpr_write, wb_csr_write,
           pipe_empty, exe_redirect, icache_flush_done,
    input  id_hold, flush_if_id, flush_id_exe, icache_flush_req,
           fencei_redirect, fencei_pc, sb_error
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_gpr_write, id_csr_access, id_csr_write, id_is_fence_i, id_pc,
           idexe_in_ready, idexe_valid, idexe_rd, idexe_gpr_write,
           idexe_csr_write, wb_valid, wb_rd, wb_gpr_write, wb_csr_write,
           pipe_empty, exe_redirect, icache_flush_done,
    output id_hold, flush_if_id, flush_id_exe, icache_flush_req,
           fencei_redirect, fencei_pc, sb_error
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32E pipeline: GPR/CSR scoreboard,
// redirect flushes and the fence.i drain / I-cache flush / refetch sequence.
module pipe_hazard_ctrl #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int CW   = 2
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [CW-1:0] csrPend_q, csrPend_d;
  logic          sbError_q, sbError_d;

  logic rawHaz, csrHaz, idHold, issue, allClear, cntErr;

  // Saturating cnt + inc - dec; err flags any clipping.
  function automatic logic [CW-1:0] satUpdate(input logic [CW-1:0] cur,
                                              input logic inc,
                                              input logic [1:0] dec,
                                              output logic err);
    logic [CW+1:0] sum;
    logic [CW+1:0] decExt;
    logic [CW-1:0] res;
    sum    = {2'b00, cur} + {{(CW+1){1'b0}}, inc};
    decExt = {{CW{1'b0}}, dec};
    err    = 1'b0;
    if (sum < decExt) begin
      err = 1'b1;
      res = '0;
    end else if ((sum - decExt) > {2'b00, {CW{1'b1}}}) begin
      err = 1'b1;
      res = '1;
    end else begin
      res = sum[CW-1:0] - decExt[CW-1:0];
    end
    return res;
  endfunction

  always_comb begin
    rawHaz = hif.id_valid &&
             ((hif.id_rs1_used && hif.id_rs1 != '0 && cnt_q[hif.id_rs1] != '0) ||
              (hif.id_rs2_used && hif.id_rs2 != '0 && cnt_q[hif.id_rs2] != '0));
    csrHaz = hif.id_valid && hif.id_csr_access && csrPend_q != '0;
    idHold = rawHaz || csrHaz || hif.exe_redirect || (state_q != IDLE) ||
             (hif.id_valid && hif.id_is_fence_i);
    issue  = hif.id_valid && !idHold && hif.idexe_in_ready;
  end

  // x0 is never tracked; a redirect cancels whatever ID/EXE held.
  always_comb begin
    logic       inc;
    logic [1:0] dec;
    logic       err;
    cntErr   = 1'b0;
    allClear = (csrPend_q == '0);
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
      if (r != 0) begin
        inc = issue && hif.id_gpr_write && hif.id_rd == AW'(r);
        dec = {1'b0, hif.wb_valid && hif.wb_gpr_write && hif.wb_rd == AW'(r)} +
              {1'b0, hif.exe_redirect && hif.idexe_valid && hif.idexe_gpr_write &&
                     hif.idexe_rd == AW'(r)};
        cnt_d[r] = satUpdate(cnt_q[r], inc, dec, err);
        cntErr   = cntErr | err;
        if (cnt_q[r] != '0) allClear = 1'b0;
      end
    end
    inc = issue && hif.id_csr_write;
    dec = {1'b0, hif.wb_valid && hif.wb_csr_write} +
          {1'b0, hif.exe_redirect && hif.idexe_valid && hif.idexe_csr_write};
    csrPend_d = satUpdate(csrPend_q, inc, dec, err);
    cntErr    = cntErr | err;
    sbError_d = sbError_q | cntErr;
  end

  always_comb begin
    state_d              = state_q;
    hif.id_hold          = idHold;
    hif.flush_if_id      = hif.exe_redirect;
    hif.flush_id_exe     = hif.exe_redirect;
    hif.icache_flush_req = 1'b0;
    hif.fencei_redirect  = 1'b0;
    hif.fencei_pc        = 32'd0;
    hif.sb_error         = sbError_q;
    unique case (state_q)
      IDLE: begin
        if (hif.id_valid && hif.id_is_fence_i && !hif.exe_redirect) state_d = DRAIN;
      end
      DRAIN: begin
        if (hif.exe_redirect) state_d = IDLE;
        else if (hif.pipe_empty && allClear) state_d = FLUSH;
      end
      FLUSH: begin
        hif.icache_flush_req = 1'b1;
        if (hif.icache_flush_done) state_d = REDIRECT;
      end
      REDIRECT: begin
        hif.fencei_redirect = 1'b1;
        hif.fencei_pc       = hif.id_pc + 32'd4;
        hif.flush_if_id     = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      csrPend_q <= '0;
      sbError_q <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q   <= state_d;
      csrPend_q <= csrPend_d;
      sbError_q <= sbError_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: scoreboard, redirect,
// fence.i sequencing, CSR serialisation, error flag and reset.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;
  int   errCount;
  int   checkCount;

  pipe_hazard_ctrl_if #(.AW(4)) hif ();

  pipe_hazard_ctrl #(.NREG(16), .AW(4), .CW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0;
    hif.id_rs1_used = 0; hif.id_rs2_used = 0; hif.id_rd = 0;
    hif.id_gpr_write = 0; hif.id_csr_access = 0; hif.id_csr_write = 0;
    hif.id_is_fence_i = 0; hif.id_pc = 0; hif.idexe_in_ready = 1;
    hif.idexe_valid = 0; hif.idexe_rd = 0; hif.idexe_gpr_write = 0;
    hif.idexe_csr_write = 0; hif.wb_valid = 0; hif.wb_rd = 0;
    hif.wb_gpr_write = 0; hif.wb_csr_write = 0; hif.pipe_empty = 1;
    hif.exe_redirect = 0; hif.icache_flush_done = 0;
  endtask

  // Start a new cycle at the falling edge with all inputs at their defaults.
  task automatic applyStimulus();
    @(negedge clk);
    clearInputs();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issueWrite(input logic [3:0] rd, input string tag);
    applyStimulus();
    hif.id_valid = 1; hif.id_rd = rd; hif.id_gpr_write = 1;
    settle();
    checkOutput(tag, 32'(hif.id_hold), 32'd0);
  endtask

  task automatic retire(input logic [3:0] rd);
    applyStimulus();
    hif.wb_valid = 1; hif.wb_rd = rd; hif.wb_gpr_write = 1;
  endtask

  task automatic readReg(input logic [3:0] rs1, input logic [3:0] rs2);
    hif.id_valid = 1; hif.id_rs1 = rs1; hif.id_rs1_used = 1;
    hif.id_rs2 = rs2; hif.id_rs2_used = 1;
  endtask

  task automatic fenceIn(input logic [31:0] pc, input logic empty);
    hif.id_valid = 1; hif.id_is_fence_i = 1; hif.id_pc = pc; hif.pipe_empty = empty;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    reset      = 1;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    settle();
    checkOutput("rst_hold", 32'(hif.id_hold), 32'd0);
    checkOutput("rst_flush_if", 32'(hif.flush_if_id), 32'd0);
    checkOutput("rst_flush_ex", 32'(hif.flush_id_exe), 32'd0);
    checkOutput("rst_req", 32'(hif.icache_flush_req), 32'd0);
    checkOutput("rst_redir", 32'(hif.fencei_redirect), 32'd0);
    checkOutput("rst_pc", hif.fencei_pc, 32'd0);
    checkOutput("rst_err", 32'(hif.sb_error), 32'd0);
    reset = 0;

    // RAW on x5 until WB commits it
    issueWrite(4'd5, "raw_issue5");
    applyStimulus(); readReg(4'd5, 4'd1); hif.id_rd = 6; hif.id_gpr_write = 1;
    settle(); checkOutput("raw_hold", 32'(hif.id_hold), 32'd1);
    applyStimulus(); readReg(4'd5, 4'd1); hif.id_rd = 6; hif.id_gpr_write = 1;
    hif.wb_valid = 1; hif.wb_rd = 5; hif.wb_gpr_write = 1;
    settle(); checkOutput("raw_hold_wb", 32'(hif.id_hold), 32'd1);
    applyStimulus(); readReg(4'd5, 4'd1); hif.id_rd = 6; hif.id_gpr_write = 1;
    settle(); checkOutput("raw_release", 32'(hif.id_hold), 32'd0);
    applyStimulus(); readReg(4'd6, 4'd0);
    settle(); checkOutput("raw_x6_busy", 32'(hif.id_hold), 32'd1);
    retire(4'd6);

    // Not ready downstream: no issue, no scoreboard entry
    applyStimulus(); hif.id_valid = 1; hif.id_rd = 14; hif.id_gpr_write = 1;
    hif.idexe_in_ready = 0;
    applyStimulus(); readReg(4'd14, 4'd6);
    settle(); checkOutput("noready_x14", 32'(hif.id_hold), 32'd0);

    // x0 handling and simultaneous inc/dec
    issueWrite(4'd0, "x0_issue");
    retire(4'd0);
    applyStimulus(); readReg(4'd0, 4'd0);
    settle(); checkOutput("x0_nohold", 32'(hif.id_hold), 32'd0);
    issueWrite(4'd7, "sim_issue7a");
    applyStimulus(); hif.id_valid = 1; hif.id_rd = 7; hif.id_gpr_write = 1;
    hif.wb_valid = 1; hif.wb_rd = 7; hif.wb_gpr_write = 1;
    settle(); checkOutput("sim_issue7b", 32'(hif.id_hold), 32'd0);
    applyStimulus(); readReg(4'd7, 4'd0);
    settle(); checkOutput("sim_cnt7_one", 32'(hif.id_hold), 32'd1);
    retire(4'd7);
    applyStimulus(); readReg(4'd7, 4'd0);
    settle(); checkOutput("sim_cnt7_zero", 32'(hif.id_hold), 32'd0);
    checkOutput("no_err_yet", 32'(hif.sb_error), 32'd0);

    // Redirect cancels the ID/EXE writer
    issueWrite(4'd9, "redir_issue9");
    applyStimulus(); hif.id_valid = 1; hif.id_rd = 10; hif.id_gpr_write = 1;
    hif.idexe_valid = 1; hif.idexe_rd = 9; hif.idexe_gpr_write = 1; hif.exe_redirect = 1;
    settle();
    checkOutput("redir_flush_if", 32'(hif.flush_if_id), 32'd1);
    checkOutput("redir_flush_ex", 32'(hif.flush_id_exe), 32'd1);
    checkOutput("redir_hold", 32'(hif.id_hold), 32'd1);
    applyStimulus(); readReg(4'd9, 4'd10);
    settle();
    checkOutput("redir_cancel", 32'(hif.id_hold), 32'd0);
    checkOutput("redir_flush_off", 32'(hif.flush_if_id), 32'd0);

    // fence.i with two writers in flight
    issueWrite(4'd11, "fi_issue11");
    issueWrite(4'd12, "fi_issue12");
    applyStimulus(); fenceIn(32'h8000_0100, 0);
    settle(); checkOutput("fi_idle_hold", 32'(hif.id_hold), 32'd1);
    applyStimulus(); fenceIn(32'h8000_0100, 0);
    hif.wb_valid = 1; hif.wb_rd = 11; hif.wb_gpr_write = 1;
    settle();
    checkOutput("fi_drain_hold", 32'(hif.id_hold), 32'd1);
    checkOutput("fi_drain_req", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus(); fenceIn(32'h8000_0100, 0);
    hif.wb_valid = 1; hif.wb_rd = 12; hif.wb_gpr_write = 1;
    settle(); checkOutput("fi_drain_req2", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus(); fenceIn(32'h8000_0100, 1);
    settle(); checkOutput("fi_drain_req3", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus(); fenceIn(32'h8000_0100, 1);
    settle();
    checkOutput("fi_flush_req", 32'(hif.icache_flush_req), 32'd1);
    checkOutput("fi_flush_noredir", 32'(hif.fencei_redirect), 32'd0);
    applyStimulus(); fenceIn(32'h8000_0100, 1); hif.icache_flush_done = 1;
    settle(); checkOutput("fi_flush_req_done", 32'(hif.icache_flush_req), 32'd1);
    applyStimulus(); fenceIn(32'h8000_0100, 1);
    settle();
    checkOutput("fi_redir", 32'(hif.fencei_redirect), 32'd1);
    checkOutput("fi_pc", hif.fencei_pc, 32'h8000_0104);
    checkOutput("fi_redir_flush_if", 32'(hif.flush_if_id), 32'd1);
    checkOutput("fi_redir_flush_ex", 32'(hif.flush_id_exe), 32'd0);
    checkOutput("fi_redir_req", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus();
    settle();
    checkOutput("fi_redir_pulse", 32'(hif.fencei_redirect), 32'd0);
    checkOutput("fi_pc_idle", hif.fencei_pc, 32'd0);
    checkOutput("fi_idle_again", 32'(hif.id_hold), 32'd0);

    // fence.i aborted by a redirect during DRAIN, then the wrapping PC case
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 0);
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 0); hif.exe_redirect = 1;
    settle();
    checkOutput("abort_flush_ex", 32'(hif.flush_id_exe), 32'd1);
    checkOutput("abort_req", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus();
    settle();
    checkOutput("abort_idle_hold", 32'(hif.id_hold), 32'd0);
    checkOutput("abort_idle_req", 32'(hif.icache_flush_req), 32'd0);
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 1);
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 1);
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 1); hif.icache_flush_done = 1;
    settle(); checkOutput("wrap_req", 32'(hif.icache_flush_req), 32'd1);
    applyStimulus(); fenceIn(32'hFFFF_FFFC, 1);
    settle();
    checkOutput("wrap_redir", 32'(hif.fencei_redirect), 32'd1);
    checkOutput("wrap_pc", hif.fencei_pc, 32'h0000_0000);

    // CSR serialisation
    applyStimulus(); hif.id_valid = 1; hif.id_csr_access = 1; hif.id_csr_write = 1;
    settle(); checkOutput("csr_issue", 32'(hif.id_hold), 32'd0);
    applyStimulus(); hif.id_valid = 1; hif.id_csr_access = 1;
    settle(); checkOutput("csr_hold", 32'(hif.id_hold), 32'd1);
    applyStimulus(); hif.id_valid = 1; hif.id_csr_access = 1;
    hif.wb_valid = 1; hif.wb_csr_write = 1;
    settle(); checkOutput("csr_hold_wb", 32'(hif.id_hold), 32'd1);
    applyStimulus(); hif.id_valid = 1; hif.id_csr_access = 1;
    settle(); checkOutput("csr_release", 32'(hif.id_hold), 32'd0);

    // Underflow sets the sticky error
    retire(4'd3);
    settle(); checkOutput("err_before", 32'(hif.sb_error), 32'd0);
    applyStimulus();
    settle(); checkOutput("err_set", 32'(hif.sb_error), 32'd1);
    applyStimulus();
    settle(); checkOutput("err_sticky", 32'(hif.sb_error), 32'd1);

    // Reset while the I-cache flush is outstanding
    applyStimulus(); fenceIn(32'h0000_2000, 1);
    applyStimulus(); fenceIn(32'h0000_2000, 1);
    applyStimulus(); fenceIn(32'h0000_2000, 1);
    settle(); checkOutput("rstf_req_pre", 32'(hif.icache_flush_req), 32'd1);
    applyStimulus(); reset = 1;
    applyStimulus(); reset = 0;
    settle();
    checkOutput("rstf_req", 32'(hif.icache_flush_req), 32'd0);
    checkOutput("rstf_hold", 32'(hif.id_hold), 32'd0);
    checkOutput("rstf_err", 32'(hif.sb_error), 32'd0);
    checkOutput("rstf_redir", 32'(hif.fencei_redirect), 32'd0);
    checkOutput("rstf_flush_if", 32'(hif.flush_if_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
